// File: rtl/key_filter_multi.sv
// key_filter_multi: per-channel debouncer for active-low mechanical keys.
// Each channel produces a debounced level plus single-cycle press, release,
// long-press and auto-repeat pulses. Channels share only clock and reset.
module key_filter_multi #(
    parameter int          KEY_NUM   = 4,
    parameter logic [19:0] CNT_MAX   = 20'd999_999,
    parameter logic [24:0] CNT_LONG  = 25'd24_999_999,
    parameter logic [23:0] CNT_REP   = 24'd4_999_999,
    parameter bit          REPEAT_EN = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] press_flag,
    output logic [KEY_NUM-1:0] release_flag,
    output logic [KEY_NUM-1:0] long_flag,
    output logic [KEY_NUM-1:0] repeat_flag
);

    localparam int DB_W     = $clog2(CNT_MAX);
    localparam int HOLD_TOP = (CNT_LONG > 25'(CNT_REP)) ? int'(CNT_LONG) : int'(CNT_REP);
    localparam int HOLD_W   = $clog2(HOLD_TOP);

    // Terminal counts: an event fires on the edge where the counter sits at N-1.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(CNT_MAX - 20'd1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(CNT_LONG - 25'd1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(CNT_REP - 24'd1);

    typedef enum logic [1:0] {
        HOLD_IDLE = 2'd0,
        HOLD_HELD = 2'd1,
        HOLD_LONG = 2'd2
    } hold_state_t;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        logic [1:0]        sync_q;
        logic [DB_W-1:0]   db_cnt_q;
        logic              stable_q;
        logic              key_on;
        logic              diff;
        logic              toggle;
        logic              press_evt;
        logic              rel_evt;
        hold_state_t       state_q;
        hold_state_t       state_d;
        logic [HOLD_W-1:0] hold_cnt_q;
        logic [HOLD_W-1:0] hold_cnt_d;
        logic              long_d;
        logic              rep_d;
        logic              press_q;
        logic              rel_q;
        logic              long_q;
        logic              rep_q;

        // Two-flop synchronizer; resets to the released level (pin high).
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) sync_q <= 2'b11;
            else            sync_q <= {sync_q[0], key_in[i]};
        end

        assign key_on    = ~sync_q[1];
        assign diff      = key_on ^ stable_q;
        assign toggle    = diff && (db_cnt_q == DB_LAST);
        assign press_evt = toggle && !stable_q;
        assign rel_evt   = toggle && stable_q;

        // Debounce: count consecutive disagreeing cycles, flip the level at the terminal count.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                db_cnt_q <= '0;
                stable_q <= 1'b0;
            end else begin
                if (!diff || toggle) db_cnt_q <= '0;
                else                 db_cnt_q <= db_cnt_q + DB_W'(1);
                stable_q <= stable_q ^ toggle;
            end
        end

        // Hold FSM next state: release always wins over a coinciding long/repeat terminal count.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            long_d     = 1'b0;
            rep_d      = 1'b0;
            case (state_q)
                HOLD_IDLE: begin
                    if (press_evt) begin
                        state_d    = HOLD_HELD;
                        hold_cnt_d = '0;
                    end
                end
                HOLD_HELD: begin
                    if (rel_evt) begin
                        state_d    = HOLD_IDLE;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == LONG_LAST) begin
                        state_d    = HOLD_LONG;
                        hold_cnt_d = '0;
                        long_d     = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                HOLD_LONG: begin
                    if (rel_evt) begin
                        state_d    = HOLD_IDLE;
                        hold_cnt_d = '0;
                    end else if (REPEAT_EN) begin
                        if (hold_cnt_q == REP_LAST) begin
                            hold_cnt_d = '0;
                            rep_d      = 1'b1;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = HOLD_IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end

        // Hold FSM register and registered event pulses, aligned with key_state.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                state_q    <= HOLD_IDLE;
                hold_cnt_q <= '0;
                press_q    <= 1'b0;
                rel_q      <= 1'b0;
                long_q     <= 1'b0;
                rep_q      <= 1'b0;
            end else begin
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
                press_q    <= press_evt;
                rel_q      <= rel_evt;
                long_q     <= long_d;
                rep_q      <= rep_d;
            end
        end

        assign key_state[i]    = stable_q;
        assign press_flag[i]   = press_q;
        assign release_flag[i] = rel_q;
        assign long_flag[i]    = long_q;
        assign repeat_flag[i]  = rep_q;
    end

endmodule

// File: tb/tb_key_filter_multi.sv
// tb_key_filter_multi: directed bench for key_filter_multi with small counts
// (CNT_MAX=25, CNT_LONG=100, CNT_REP=40). A second instance with
// REPEAT_EN=0 shares all inputs.
module tb_key_filter_multi;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [3:0] key_in;

    logic [3:0] key_state, press_flag, release_flag, long_flag, repeat_flag;
    logic [3:0] key_state_nr, press_flag_nr, release_flag_nr, long_flag_nr, repeat_flag_nr;

    int n_compared = 0;
    int n_mismatch = 0;

    // Pulse tallies per channel, observed at every rising edge.
    int n_press [4] = '{0, 0, 0, 0};
    int n_rel   [4] = '{0, 0, 0, 0};
    int n_long  [4] = '{0, 0, 0, 0};
    int n_rep   [4] = '{0, 0, 0, 0};
    int n_long_nr [4] = '{0, 0, 0, 0};
    int n_rep_nr  [4] = '{0, 0, 0, 0};
    int n_multi = 0;

    key_filter_multi #(
        .KEY_NUM(4), .CNT_MAX(20'd25), .CNT_LONG(25'd100), .CNT_REP(24'd40), .REPEAT_EN(1'b1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
        .key_state(key_state), .press_flag(press_flag), .release_flag(release_flag),
        .long_flag(long_flag), .repeat_flag(repeat_flag)
    );

    key_filter_multi #(
        .KEY_NUM(4), .CNT_MAX(20'd25), .CNT_LONG(25'd100), .CNT_REP(24'd40), .REPEAT_EN(1'b0)
    ) dut_nr (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
        .key_state(key_state_nr), .press_flag(press_flag_nr), .release_flag(release_flag_nr),
        .long_flag(long_flag_nr), .repeat_flag(repeat_flag_nr)
    );

    // Clock: 20 ns period.
    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    // Pulse tallies and the one-flag-per-channel-per-cycle property.
    always @(posedge sys_clk) begin
        for (int c = 0; c < 4; c++) begin
            if (press_flag[c])     n_press[c]++;
            if (release_flag[c])   n_rel[c]++;
            if (long_flag[c])      n_long[c]++;
            if (repeat_flag[c])    n_rep[c]++;
            if (long_flag_nr[c])   n_long_nr[c]++;
            if (repeat_flag_nr[c]) n_rep_nr[c]++;
            if ($countones({press_flag[c], release_flag[c], long_flag[c], repeat_flag[c]}) > 1)
                n_multi++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatch++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [0:19] bounce_pat;
    int b_press, b_rel, b_long, b_rep, b_long_nr, b_rep_nr;
    int b_rel0, b_rel1, b_rel2, b_rel3;

    initial begin
        // ---------------- reset ----------------
        sys_rst_n = 1'b0;
        key_in    = 4'hF;
        tick(3);
        check("reset_outputs", {key_state, press_flag, release_flag, long_flag, repeat_flag}, 32'h0);
        check("reset_outputs_nr", {key_state_nr, press_flag_nr, release_flag_nr, long_flag_nr, repeat_flag_nr}, 32'h0);
        sys_rst_n = 1'b1;
        tick(2);

        // ---------------- clean press/release on ch0 ----------------
        b_long = n_long[0];
        key_in[0] = 1'b0;
        tick(26);
        check("ch0_press_early", {key_state, press_flag}, 32'h00);
        tick(1);
        check("ch0_press_flag", press_flag, 32'h1);
        check("ch0_key_state", key_state, 32'h1);
        tick(1);
        check("ch0_press_width", press_flag, 32'h0);
        tick(58);
        key_in[0] = 1'b1;
        tick(26);
        check("ch0_release_early", {key_state, release_flag}, 32'h10);
        tick(1);
        check("ch0_release_flag", release_flag, 32'h1);
        check("ch0_key_state_off", key_state, 32'h0);
        tick(1);
        check("ch0_release_width", release_flag, 32'h0);
        check("ch0_no_long", n_long[0] - b_long, 32'd0);
        check("ch123_no_press", n_press[1] + n_press[2] + n_press[3], 32'd0);

        // ---------------- bounce on ch1 ----------------
        bounce_pat = 20'b1010_0110_1100_0101_1010;
        b_press = n_press[1];
        for (int i = 0; i < 20; i++) begin
            key_in[1] = bounce_pat[i];
            tick(1);
        end
        tick(25);
        check("ch1_bounce_early", press_flag, 32'h0);
        tick(1);
        check("ch1_bounce_press", press_flag, 32'h2);
        check("ch1_bounce_state", key_state, 32'h2);
        tick(5);
        check("ch1_bounce_once", n_press[1] - b_press, 32'd1);
        key_in[1] = 1'b1;
        tick(30);
        check("ch1_bounce_release", key_state, 32'h0);

        // 24-cycle glitch must be rejected
        b_press = n_press[1];
        key_in[1] = 1'b0;
        tick(24);
        key_in[1] = 1'b1;
        tick(2);
        check("ch1_glitch_state_mid", key_state, 32'h0);
        tick(30);
        check("ch1_glitch_state", key_state, 32'h0);
        check("ch1_glitch_no_press", n_press[1] - b_press, 32'd0);

        // ---------------- long + repeat on ch2 ----------------
        b_long = n_long[2];  b_rep = n_rep[2];  b_rel = n_rel[2];
        b_long_nr = n_long_nr[2];  b_rep_nr = n_rep_nr[2];
        key_in[2] = 1'b0;
        tick(27);
        check("ch2_press", press_flag, 32'h4);
        tick(99);
        check("ch2_long_early", long_flag, 32'h0);
        tick(1);
        check("ch2_long_100", long_flag, 32'h4);
        check("ch2_long_100_nr", long_flag_nr, 32'h4);
        tick(39);
        check("ch2_rep_early", repeat_flag, 32'h0);
        tick(1);
        check("ch2_rep_140", repeat_flag, 32'h4);
        check("ch2_rep_140_nr", repeat_flag_nr, 32'h0);
        tick(35);
        key_in[2] = 1'b1;
        tick(5);
        check("ch2_rep_180", repeat_flag, 32'h4);
        check("ch2_rep_180_nr", repeat_flag_nr, 32'h0);
        tick(21);
        check("ch2_release_early", release_flag, 32'h0);
        tick(1);
        check("ch2_release", release_flag, 32'h4);
        tick(60);
        check("ch2_long_count", n_long[2] - b_long, 32'd1);
        check("ch2_rep_count", n_rep[2] - b_rep, 32'd2);
        check("ch2_rel_count", n_rel[2] - b_rel, 32'd1);
        check("ch2_long_count_nr", n_long_nr[2] - b_long_nr, 32'd1);
        check("ch2_rep_count_nr", n_rep_nr[2] - b_rep_nr, 32'd0);

        // ---------------- all keys together, ch3 released at long terminal ----------------
        b_rel0 = n_rel[0];  b_rel1 = n_rel[1];  b_rel2 = n_rel[2];  b_rel3 = n_rel[3];
        b_long = n_long[3];  b_rep = n_rep[0] + n_rep[1] + n_rep[2] + n_rep[3];
        key_in = 4'h0;
        tick(26);
        check("all_press_early", press_flag, 32'h0);
        tick(1);
        check("all_press", press_flag, 32'hF);
        check("all_state", key_state, 32'hF);
        tick(73);
        key_in[3] = 1'b1;
        tick(26);
        check("all_long_early", long_flag, 32'h0);
        tick(1);
        check("coincide_long", long_flag, 32'h7);
        check("coincide_release", release_flag, 32'h8);
        check("coincide_long_nr", long_flag_nr, 32'h7);
        key_in = 4'hF;
        tick(1);
        check("coincide_after", {long_flag, release_flag}, 32'h00);
        tick(40);
        check("all_released", key_state, 32'h0);
        check("ch3_no_long", n_long[3] - b_long, 32'd0);
        check("all_rel_counts", {8'(n_rel[3] - b_rel3), 8'(n_rel[2] - b_rel2),
                                 8'(n_rel[1] - b_rel1), 8'(n_rel[0] - b_rel0)}, 32'h01010101);
        check("all_no_repeat", (n_rep[0] + n_rep[1] + n_rep[2] + n_rep[3]) - b_rep, 32'd0);

        // ---------------- reset while ch0 in LONG ----------------
        b_rel = n_rel[0];
        key_in[0] = 1'b0;
        tick(27);
        check("rst_ch0_press", press_flag, 32'h1);
        tick(110);
        check("rst_ch0_held", key_state, 32'h1);
        sys_rst_n = 1'b0;
        #2;
        check("rst_immediate", {key_state, press_flag, release_flag, long_flag, repeat_flag}, 32'h0);
        tick(3);
        check("rst_no_release", n_rel[0] - b_rel, 32'd0);
        sys_rst_n = 1'b1;
        tick(26);
        check("rst_repress_early", {key_state, press_flag}, 32'h00);
        tick(1);
        check("rst_repress", press_flag, 32'h1);
        key_in = 4'hF;
        tick(40);
        check("rst_single_release", n_rel[0] - b_rel, 32'd1);

        check("one_flag_per_cycle", n_multi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/key_filter_multi.md
# key_filter_multi

Multi-channel key debouncer with press, release, long-press and auto-repeat event detection. It replaces the single-channel key filter wherever a board exposes more than one mechanical key. It sits directly behind the raw key pins and feeds single-cycle event pulses to control logic such as menu FSMs or counter increment and decrement paths. All channels are independent and share only clock and reset.

## Interface
- KEY_NUM, 4, number of key channels (≥1)
- CNT_MAX, 20'd999_999, debounce window in sys_clk cycles (≥2; 20 ms at 50 MHz)
- CNT_LONG, 25'd24_999_999, hold time from press_flag to long_flag in cycles (≥2)
- CNT_REP, 24'd4_999_999, auto-repeat period after long_flag in cycles (≥2)
- REPEAT_EN, 1'b1, 1 = emit repeat_flag while held after long press; 0 = no repeat
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- key_in  in  KEY_NUM  raw key pins, active-low (0 = pressed), asynchronous to sys_clk
- key_state  out  KEY_NUM  debounced level, 1 = pressed
- press_flag  out  KEY_NUM  1-cycle pulse on debounced press
- release_flag  out  KEY_NUM  1-cycle pulse on debounced release
- long_flag  out  KEY_NUM  1-cycle pulse when hold reaches CNT_LONG
- repeat_flag  out  KEY_NUM  1-cycle pulse every CNT_REP cycles after long_flag (REPEAT_EN=1 only)

## Operation
- Per channel: 2-FF synchronizer (reset value 1 = released), debounce counter, stable-level register, hold counter, and a 3-state hold FSM.
- Debounce: the counter increments on every cycle in which the synchronized input differs from the stable level, and clears to 0 on any cycle in which they are equal. A glitch shorter than CNT_MAX cycles never changes key_state.
- When the counter equals CNT_MAX-1 and the input still differs, the stable level toggles on the next edge and the counter clears.
- press_flag / release_flag are registered with key_state and are high exactly in the first cycle of the new key_state value.
- Hold FSM states:
  - IDLE: key_state=0.
  - HELD: entered with press_flag; hold counter cleared.
  - LONG: entered from HELD when hold counter = CNT_LONG-1; long_flag pulses in that cycle.
- In LONG with REPEAT_EN=1: the counter reloads to 0 at entry. repeat_flag pulses when it equals CNT_REP-1, then the counter wraps to 0 and repeats.
- In LONG with REPEAT_EN=0: the counter freezes. There is never a second long_flag and never a repeat_flag.
- Release (key_state 1→0) from HELD or LONG: go to IDLE and clear the hold counter in the release_flag cycle.
- If release coincides with a long or repeat terminal count, the release wins and the long or repeat pulse is suppressed.
- Channels are fully independent. Simultaneous events on several channels all produce their own pulses in the same cycle.
- Counter widths: debounce counter $clog2(CNT_MAX) bits, hold counter $clog2(max(CNT_LONG,CNT_REP)) bits. Counters never overflow because they compare against terminal counts.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert handled upstream):
  - key_state=0; all flags=0; counters=0; FSM=IDLE; synchronizers=1.
  - Effective immediately, including mid-hold or mid-debounce.
  - No release_flag is emitted for a key that was pressed when reset asserted.
- Key held low through reset deassertion: treated as a fresh press, so press_flag fires after normal latency.
- Press latency: clean key_in fall sampled at edge N gives key_state=1 and press_flag=1 during the cycle after edge N+CNT_MAX+1, i.e. CNT_MAX+2 edges. Release latency is identical.
- long_flag occurs exactly CNT_LONG cycles after the press_flag cycle.
- The first repeat_flag occurs CNT_REP cycles after long_flag; subsequent ones follow every CNT_REP cycles.
- All flags are exactly 1 cycle wide. At most one of press/release/long/repeat is high per channel per cycle.

## Test plan
Parameters for all scenarios: KEY_NUM=4, CNT_MAX=25, CNT_LONG=100, CNT_REP=40, 20 ns clock.
- Clean press on ch0 only, held 60 cycles, then clean release:
  - press_flag[0] pulses 27 edges after key_in[0] falls, and key_state[0] goes 1 in the same cycle.
  - release_flag[0] pulses 27 edges after key_in[0] rises.
  - No long_flag.
  - Channels 1–3 stay 0.
- Bounce:
  - Random key_in[1] toggling for 20 cycles, then stable low → exactly one press_flag[1], 27 edges after the last toggle.
  - A 24-cycle low glitch → no flag and key_state[1] stays 0.
- Long plus repeat: ch2 held 200 cycles past press_flag, then released:
  - long_flag[2] at +100.
  - repeat_flag[2] at +140 and +180.
  - release_flag[2] once.
  - No repeat after release.
- REPEAT_EN=0, same stimulus → a single long_flag at +100 and zero repeat_flag.
- All 4 keys pressed in the same cycle → four press_flag bits high in the same cycle. Releasing ch3 exactly at its long terminal count → release_flag[3] only, with long_flag[3] suppressed.
- Reset asserted while ch0 is in LONG → all outputs 0 immediately and no release_flag. With key_in[0] still low after reset deassertion → press_flag[0] 27 edges later.
